// File: rtl/complex_pkg.sv
// Shared definitions for the complex arithmetic datapath: component width,
// packed {re, im} type, pack/unpack helpers and saturation limits.
package complex_pkg;

    localparam int unsigned CPLX_W = 8;

    typedef logic signed [CPLX_W-1:0] cplx_comp_t;

    typedef struct packed {
        cplx_comp_t re;
        cplx_comp_t im;
    } cplx_t;

    localparam cplx_comp_t CPLX_SAT_MAX = {1'b0, {(CPLX_W-1){1'b1}}};
    localparam cplx_comp_t CPLX_SAT_MIN = {1'b1, {(CPLX_W-1){1'b0}}};

    function automatic cplx_comp_t get_re(input cplx_t c);
        return c.re;
    endfunction

    function automatic cplx_comp_t get_im(input cplx_t c);
        return c.im;
    endfunction

    function automatic cplx_t mk_cplx(input cplx_comp_t re, input cplx_comp_t im);
        cplx_t c;
        c.re = re;
        c.im = im;
        return c;
    endfunction

endpackage

// File: rtl/add_sub_lane.sv
// One W-bit signed lane of the complex adder/subtractor, purely combinational.
// Build option: ADD_SUB_SATURATE_EN clamps the result on overflow instead of wrapping.
module add_sub_lane #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] res_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] SatMax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SatMin = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] b_eff;
    logic [W-1:0] sum;

    // Subtract as a + ~b + 1; overflow when the effective operands share a sign
    // and the result sign differs from it.
    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        sum   = a_i + b_eff + W'(sub_i);
        ovf_o = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);
`ifdef ADD_SUB_SATURATE_EN
        // On overflow the true result carries the sign of a.
        if (ovf_o) begin
            res_o = a_i[W-1] ? SatMin : SatMax;
        end else begin
            res_o = sum;
        end
`else
        res_o = sum;
`endif
    end

endmodule

// File: rtl/add_sub.sv
// Registered complex adder/subtractor: out = a +/- b per {re, im} lane, 1-cycle latency.
// Build option: ADD_SUB_SATURATE_EN (saturate lanes on overflow, see add_sub_lane).
module add_sub
    import complex_pkg::*;
#(
    parameter int unsigned W = CPLX_W
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    input  logic [2*W-1:0] a_i,
    input  logic [2*W-1:0] b_i,
    input  logic           mode_i,
    output logic           out_valid_o,
    output logic [2*W-1:0] out_o,
    output logic           ovf_re_o,
    output logic           ovf_im_o
);

    logic [W-1:0]   res_re;
    logic [W-1:0]   res_im;
    logic           ovf_re;
    logic           ovf_im;

    logic [2*W-1:0] out_d, out_q;
    logic           out_valid_d, out_valid_q;
    logic           ovf_re_d, ovf_re_q;
    logic           ovf_im_d, ovf_im_q;

    add_sub_lane #(
        .W (W)
    ) u_lane_re (
        .a_i   (a_i[2*W-1:W]),
        .b_i   (b_i[2*W-1:W]),
        .sub_i (mode_i),
        .res_o (res_re),
        .ovf_o (ovf_re)
    );

    add_sub_lane #(
        .W (W)
    ) u_lane_im (
        .a_i   (a_i[W-1:0]),
        .b_i   (b_i[W-1:0]),
        .sub_i (mode_i),
        .res_o (res_im),
        .ovf_o (ovf_im)
    );

    // Capture a new result on valid input; otherwise hold data and drop valid.
    always_comb begin
        out_d       = out_q;
        ovf_re_d    = ovf_re_q;
        ovf_im_d    = ovf_im_q;
        out_valid_d = in_valid_i;
        if (in_valid_i) begin
            out_d    = {res_re, res_im};
            ovf_re_d = ovf_re;
            ovf_im_d = ovf_im;
        end
    end

    // Output registers with synchronous active-low reset (reset beats in_valid).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_re_q    <= 1'b0;
            ovf_im_q    <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_re_q    <= ovf_re_d;
            ovf_im_q    <= ovf_im_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign ovf_re_o    = ovf_re_q;
    assign ovf_im_o    = ovf_im_q;

endmodule

// File: tb/tb_add_sub.sv
// Directed self-checking bench for add_sub (W=8). Honors ADD_SUB_SATURATE_EN.
module tb_add_sub;
    import complex_pkg::*;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic           mode;
    logic           out_valid;
    logic [2*W-1:0] out;
    logic           ovf_re;
    logic           ovf_im;

    int errors = 0;
    int checks = 0;

    add_sub #(
        .W (W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .a_i         (a),
        .b_i         (b),
        .mode_i      (mode),
        .out_valid_o (out_valid),
        .out_o       (out),
        .ovf_re_o    (ovf_re),
        .ovf_im_o    (ovf_im)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] c(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        r = re;
        i = im;
        return mk_cplx(r[7:0], i[7:0]);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv,
                         input logic m);
        in_valid = v;
        a        = av;
        b        = bv;
        mode     = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with in_valid high: result must be discarded.
        rst_n = 1'b0;
        drive(1'b1, c(5, 5), c(1, 1), 1'b0);
        tick();
        tick();
        chk("rst_out", out, 16'h0000);
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_ovf", 16'({ovf_re, ovf_im}), 16'd0);

        rst_n = 1'b1;

        // Plain subtract.
        drive(1'b1, c(-9, 24), c(54, -1), 1'b1);
        tick();
        chk("t1_out", out, c(-63, 25));
        chk("t1_valid", 16'(out_valid), 16'd1);
        chk("t1_ovf", 16'({ovf_re, ovf_im}), 16'd0);

        // Back-to-back adds.
        drive(1'b1, c(10, 36), c(22, -4), 1'b0);
        tick();
        chk("t2a_out", out, c(32, 32));
        chk("t2a_valid", 16'(out_valid), 16'd1);
        drive(1'b1, c(2, 81), c(0, 2), 1'b0);
        tick();
        chk("t2b_out", out, c(2, 83));
        chk("t2b_valid", 16'(out_valid), 16'd1);

        // Subtract then idle: data holds, valid drops.
        drive(1'b1, c(43, 30), c(-12, -7), 1'b1);
        tick();
        chk("t3a_out", out, c(55, 37));
        drive(1'b0, c(1, 1), c(1, 1), 1'b0);
        tick();
        chk("t3b_out", out, c(55, 37));
        chk("t3b_valid", 16'(out_valid), 16'd0);

        // Overflow, add.
        drive(1'b1, c(127, -128), c(1, 1), 1'b0);
        tick();
`ifdef ADD_SUB_SATURATE_EN
        chk("t4a_out", out, c(127, -127));
`else
        chk("t4a_out", out, c(-128, -127));
`endif
        chk("t4a_ovf", 16'({ovf_re, ovf_im}), 16'b10);

        // Overflow, subtract.
        drive(1'b1, c(127, -128), c(1, 1), 1'b1);
        tick();
`ifdef ADD_SUB_SATURATE_EN
        chk("t4b_out", out, c(126, -128));
`else
        chk("t4b_out", out, c(126, 127));
`endif
        chk("t4b_ovf", 16'({ovf_re, ovf_im}), 16'b01);

        // Idle with changed mode/operands: everything but valid holds.
        drive(1'b0, c(0, 0), c(-128, -128), 1'b0);
        tick();
        chk("hold_ovf", 16'({ovf_re, ovf_im}), 16'b01);
        chk("hold_valid", 16'(out_valid), 16'd0);

        // -128 - 1 and 0 - (-128).
        drive(1'b1, c(-128, 0), c(1, -128), 1'b1);
        tick();
`ifdef ADD_SUB_SATURATE_EN
        chk("bnd_sub_out", out, c(-128, 127));
`else
        chk("bnd_sub_out", out, c(127, -128));
`endif
        chk("bnd_sub_ovf", 16'({ovf_re, ovf_im}), 16'b11);

        // -1 + 1 = 0 without overflow, carry stays out of Re.
        drive(1'b1, c(-1, -1), c(1, 1), 1'b0);
        tick();
        chk("bnd_add_out", out, c(0, 0));
        chk("bnd_add_ovf", 16'({ovf_re, ovf_im}), 16'b00);

        // Lane isolation: Im borrow must not reach Re.
        drive(1'b1, c(5, 0), c(0, 1), 1'b1);
        tick();
        chk("lane_out", out, c(5, -1));

        // Reset after a valid result, with in_valid held high.
        drive(1'b1, c(100, 100), c(100, 100), 1'b0);
        tick();
        chk("pre_rst_ovf", 16'({ovf_re, ovf_im}), 16'b11);
        rst_n = 1'b0;
        tick();
        chk("rst2_out", out, 16'h0000);
        chk("rst2_valid", 16'(out_valid), 16'd0);
        chk("rst2_ovf", 16'({ovf_re, ovf_im}), 16'd0);
        rst_n = 1'b1;
        drive(1'b1, c(3, -4), c(-5, 6), 1'b0);
        tick();
        chk("post_rst_out", out, c(-2, 2));
        chk("post_rst_valid", 16'(out_valid), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
